// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the serial slice comparator:
//   - FSM state encodings (2-bit, legacy-compatible localparams)
//   - SLICE_W: bits compared per cycle
//   - slice_cfg(): derives slice count and slice-index width from WIDTH
// -----------------------------------------------------------------------------
package cmp_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int SLICE_W = 2;

    typedef struct packed {
        logic [31:0] nslice;
        logic [31:0] idx_w;
    } slice_cfg_t;

    // Number of slices and the index width needed to address them (min 1 bit).
    function automatic slice_cfg_t slice_cfg(input int width);
        slice_cfg_t cfg;
        int         n;
        n          = width / SLICE_W;
        cfg.nslice = 32'(n);
        cfg.idx_w  = (n > 1) ? 32'($clog2(n)) : 32'd1;
        return cfg;
    endfunction

endpackage

// File: rtl/two_bit_comparator.sv
// -----------------------------------------------------------------------------
// two_bit_comparator
// Combinational magnitude comparator for one 2-bit unsigned slice.
// Ports:
//   a_i, b_i : slice operands
//   eq_o     : a_i == b_i
//   gt_o     : a_i >  b_i
//   lt_o     : a_i <  b_i
// -----------------------------------------------------------------------------
module two_bit_comparator
    import cmp_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    output logic               eq_o,
    output logic               gt_o,
    output logic               lt_o
);

    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i >  b_i);
    assign lt_o = (a_i <  b_i);

endmodule

// File: rtl/serial_slice_comparator.sv
// -----------------------------------------------------------------------------
// serial_slice_comparator
// Multi-cycle unsigned magnitude comparator. One 2-bit slice of the latched
// operands is fed per cycle, MSB slice first, to a single two_bit_comparator;
// the first unequal slice decides gt/lt, otherwise eq.
// Ports:
//   clk   : clock, all state on posedge
//   rst   : synchronous active-high reset
//   start : request, accepted in IDLE or DONE only
//   a, b  : operands, sampled on the accepted start
//   busy  : high while scanning (RUN)
//   done  : one-cycle pulse, high exactly in DONE
//   eq/gt/lt : registered verdict, held until the next accepted start
// Configuration macro:
//   EARLY_EXIT_EN : stop scanning at the first unequal slice; otherwise every
//                   slice is scanned for constant latency.
// -----------------------------------------------------------------------------
module serial_slice_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam slice_cfg_t            CFG     = slice_cfg(WIDTH);
    localparam int                    NSLICE  = int'(CFG.nslice);
    localparam int                    IDX_W   = int'(CFG.idx_w);
    localparam logic [IDX_W-1:0]      IDX_TOP = IDX_W'(NSLICE - 1);
    localparam logic [IDX_W-1:0]      IDX_ONE = IDX_W'(1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             busy_q;
    logic             done_q;

    logic [SLICE_W-1:0] a_slice_s;
    logic [SLICE_W-1:0] b_slice_s;
    logic               cmp_eq_s;
    logic               cmp_gt_s;
    logic               cmp_lt_s;
    logic               last_s;

`ifndef EARLY_EXIT_EN
    // Sticky record of the first unequal slice so later slices cannot override it.
    logic seen_q, seen_d;
    logic vgt_q, vgt_d;
    logic vlt_q, vlt_d;
`endif

    // Current slice of the latched operands; index scaled by SLICE_W (=2).
    assign a_slice_s = a_q[{idx_q, 1'b0} +: SLICE_W];
    assign b_slice_s = b_q[{idx_q, 1'b0} +: SLICE_W];

    two_bit_comparator u_cmp (
        .a_i  (a_slice_s),
        .b_i  (b_slice_s),
        .eq_o (cmp_eq_s),
        .gt_o (cmp_gt_s),
        .lt_o (cmp_lt_s)
    );

`ifdef EARLY_EXIT_EN
    assign last_s = !cmp_eq_s || (idx_q == {IDX_W{1'b0}});
`else
    assign last_s = (idx_q == {IDX_W{1'b0}});
`endif

    // Next-state and datapath update for the sequencer FSM.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
`ifndef EARLY_EXIT_EN
        seen_d  = seen_q;
        vgt_d   = vgt_q;
        vlt_d   = vlt_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IDX_TOP;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
`ifndef EARLY_EXIT_EN
                    seen_d  = 1'b0;
                    vgt_d   = 1'b0;
                    vlt_d   = 1'b0;
`endif
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
`ifdef EARLY_EXIT_EN
                if (last_s) begin
                    eq_d    = cmp_eq_s;
                    gt_d    = cmp_gt_s;
                    lt_d    = cmp_lt_s;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q - IDX_ONE;
                end
`else
                if (!seen_q && !cmp_eq_s) begin
                    seen_d = 1'b1;
                    vgt_d  = cmp_gt_s;
                    vlt_d  = cmp_lt_s;
                end else begin
                    seen_d = seen_q;
                end
                if (last_s) begin
                    eq_d    = !seen_q && cmp_eq_s;
                    gt_d    = seen_q ? vgt_q : cmp_gt_s;
                    lt_d    = seen_q ? vlt_q : cmp_lt_s;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q - IDX_ONE;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; busy/done decode the next state so they are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifndef EARLY_EXIT_EN
            seen_q  <= 1'b0;
            vgt_q   <= 1'b0;
            vlt_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            busy_q  <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
`ifndef EARLY_EXIT_EN
            seen_q  <= seen_d;
            vgt_q   <= vgt_d;
            vlt_q   <= vlt_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;

endmodule
